inst_fetch_unit: RTL and testbench

//  Consumes the controller's PC-steering outputs (pc_src, jump, jr) and supplies it the current instruction.

---
 rtl/inst_fetch_unit_pkg.sv | 27 ++
 rtl/inst_fetch_unit_next_pc_calc.sv | 59 +++++
 rtl/inst_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: word/address widths,
// the MIPS opcodes the fetch path cares about, and the 2-bit fetch FSM
// state encoding.
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 32;

  // Primary opcodes (inst[31:26]) of the control-flow instructions that
  // steer the PC. The controller decodes these; they are kept here so the
  // fetch unit and controller agree on one definition.
  localparam logic [5:0] OP_RTYPE = 6'h00;  // jr lives under funct
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } fetch_state_t;

endpackage : inst_fetch_unit_pkg

// File: rtl/inst_fetch_unit_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection for the fetch unit.
// Priority: jr > jump > branch (pc_src) > sequential.
// Ports:
//   pc_plus4   in  32  pc + 4 of the instruction in execute
//   inst       in  32  instruction in execute
//   rs_data    in  32  register rs value (jr target)
//   pc_src     in  1   branch taken
//   jump       in  1   j / jal
//   jr         in  1   jump register
//   next_pc    out 32  selected next PC (word aligned)
//   misaligned out 1   jr selected and rs_data[1:0] != 0
// -----------------------------------------------------------------------------
module next_pc_calc
  import inst_fetch_unit_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] pc_plus4,
  input  logic [WORD_WIDTH-1:0] inst,
  input  logic [WORD_WIDTH-1:0] rs_data,
  input  logic                  pc_src,
  input  logic                  jump,
  input  logic                  jr,
  output logic [WORD_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  logic [WORD_WIDTH-1:0] w_jr_target;
  logic [WORD_WIDTH-1:0] w_jump_target;
  logic [WORD_WIDTH-1:0] w_branch_offset;
  logic [WORD_WIDTH-1:0] w_branch_target;

  // The opcode field is decoded by the controller, not here.
  logic w_unused_opcode;
  assign w_unused_opcode = &{1'b0, inst[31:26]};

  // Low bits are dropped so the PC always stays word aligned; a nonzero
  // value there is reported rather than honoured.
  assign w_jr_target     = {rs_data[31:2], 2'b00};
  assign w_jump_target   = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign w_branch_offset = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign w_branch_target = pc_plus4 + w_branch_offset;  // wraps mod 2^32

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    if (jr) begin
      next_pc    = w_jr_target;
      misaligned = (rs_data[1:0] != 2'b00);
    end else if (jump) begin
      next_pc = w_jump_target;
    end else if (pc_src) begin
      next_pc = w_branch_target;
    end
  end

endmodule : next_pc_calc

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Owns the PC and the instruction-memory req/ack handshake of the
// single-issue MIPS core. Each instruction takes one fetch (S_FETCH, wait
// for ack) and at least one execute cycle (S_EXEC), where the controller's
// steering outputs select the next PC on the exit edge.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   inst_req      out  fetch request (high throughout S_FETCH)
//   inst_addr     out  fetch address (= pc)
//   inst_ack      in   inst_rdata valid this cycle (honoured only in S_FETCH)
//   inst_rdata    in   fetched instruction word
//   inst          out  registered instruction for controller/datapath
//   inst_valid    out  inst is live (S_EXEC)
//   pc, pc_plus4  out  current PC and its sequential successor (jal link)
//   pc_src, jump, jr, rs_data  in  PC steering, sampled on the S_EXEC exit
//   stall         in   hold the current instruction in execute
//   misalign_err  out  one-cycle pulse after a jr with rs_data[1:0] != 0
//   inst_count    out  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int                         WORD_WIDTH     = 32,
  parameter int                         MEM_ADDR_WIDTH = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0]  RESET_PC       = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      inst_req,
  output logic [MEM_ADDR_WIDTH-1:0] inst_addr,
  input  logic                      inst_ack,
  input  logic [WORD_WIDTH-1:0]     inst_rdata,
  output logic [WORD_WIDTH-1:0]     inst,
  output logic                      inst_valid,
  output logic [MEM_ADDR_WIDTH-1:0] pc,
  output logic [MEM_ADDR_WIDTH-1:0] pc_plus4,
  input  logic                      pc_src,
  input  logic                      jump,
  input  logic                      jr,
  input  logic [WORD_WIDTH-1:0]     rs_data,
  input  logic                      stall,
  output logic                      misalign_err,
  output logic [31:0]               inst_count
);

  import inst_fetch_unit_pkg::*;

  fetch_state_t              r_state;
  fetch_state_t              w_state_next;
  logic [MEM_ADDR_WIDTH-1:0] r_pc;
  logic [WORD_WIDTH-1:0]     r_inst;
  logic                      r_misalign_err;
  logic [31:0]               r_inst_count;

  logic [MEM_ADDR_WIDTH-1:0] w_next_pc;
  logic                      w_misaligned;
  logic                      w_fetch_done;
  logic                      w_exec_exit;

  assign w_fetch_done = (r_state == S_FETCH) && inst_ack;
  assign w_exec_exit  = (r_state == S_EXEC) && !stall;

  assign pc_plus4 = r_pc + MEM_ADDR_WIDTH'(4);  // 0xFFFF_FFFC wraps to 0

  next_pc_calc u_next_pc_calc (
    .pc_plus4   (pc_plus4),
    .inst       (r_inst),
    .rs_data    (rs_data),
    .pc_src     (pc_src),
    .jump       (jump),
    .jr         (jr),
    .next_pc    (w_next_pc),
    .misaligned (w_misaligned)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_RESET;
    else     r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_RESET: w_state_next = S_FETCH;
      S_FETCH: if (inst_ack) w_state_next = S_EXEC;
      S_EXEC:  if (!stall)   w_state_next = S_FETCH;
      default: w_state_next = S_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Decoded straight from state so the async reset drops
  // inst_req in the same instant it takes effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_req   = 1'b0;
    inst_valid = 1'b0;
    unique case (r_state)
      S_FETCH: inst_req   = 1'b1;
      S_EXEC:  inst_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: PC, instruction register, error pulse, retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_inst         <= '0;
      r_misalign_err <= 1'b0;
      r_inst_count   <= '0;
    end else begin
      // Pulse only on the exit edge of a misaligned jr; cleared otherwise.
      r_misalign_err <= w_exec_exit && w_misaligned;
      if (w_fetch_done) begin
        r_inst <= inst_rdata;
      end
      if (w_exec_exit) begin
        r_pc         <= w_next_pc;
        r_inst_count <= r_inst_count + 32'd1;
      end
    end
  end

  assign inst_addr    = r_pc;
  assign pc           = r_pc;
  assign inst         = r_inst;
  assign misalign_err = r_misalign_err;
  assign inst_count   = r_inst_count;

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit. Inputs are driven and outputs sampled
// on the falling clock edge, away from the rising edge the DUT acts on.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic        jump;
  logic        jr;
  logic [31:0] rs_data;
  logic        stall;
  logic        misalign_err;
  logic [31:0] inst_count;

  int n_compared;
  int n_mismatched;
  int exp_count;
  int valid_cycles;

  inst_fetch_unit #(
    .WORD_WIDTH     (32),
    .MEM_ADDR_WIDTH (32),
    .RESET_PC       (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ack     (inst_ack),
    .inst_rdata   (inst_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_src       (pc_src),
    .jump         (jump),
    .jr           (jr),
    .rs_data      (rs_data),
    .stall        (stall),
    .misalign_err (misalign_err),
    .inst_count   (inst_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until the DUT is requesting a fetch.
  task automatic wait_fetch(input string tag);
    int n;
    n = 0;
    while (inst_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, inst_req}, 32'd1);
  endtask

  // One instruction: zero-wait ack with `word`, then one execute cycle with
  // the given steering. Returns on the falling edge after the exit edge.
  task automatic run_inst(input string tag, input logic [31:0] word,
                          input logic c_pc_src, input logic c_jump,
                          input logic c_jr, input logic [31:0] c_rs);
    wait_fetch({tag, "_req"});
    inst_ack   = 1'b1;
    inst_rdata = word;
    @(negedge clk);
    inst_ack   = 1'b0;
    inst_rdata = 32'hDEAD_BEEF;
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    pc_src  = c_pc_src;
    jump    = c_jump;
    jr      = c_jr;
    rs_data = c_rs;
    @(negedge clk);
    pc_src  = 1'b0;
    jump    = 1'b0;
    jr      = 1'b0;
    rs_data = 32'h0;
    exp_count++;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    exp_count    = 0;
    rst        = 1'b1;
    inst_ack   = 1'b0;
    inst_rdata = 32'h0;
    pc_src     = 1'b0;
    jump       = 1'b0;
    jr         = 1'b0;
    rs_data    = 32'h0;
    stall      = 1'b0;

    // ---- Reset state ----
    #2;
    check("rst_req",   {31'd0, inst_req},     32'd0);
    check("rst_valid", {31'd0, inst_valid},   32'd0);
    check("rst_pc",    pc,                    32'h0);
    check("rst_inst",  inst,                  32'h0);
    check("rst_count", inst_count,            32'd0);
    check("rst_merr",  {31'd0, misalign_err}, 32'd0);

    // ---- 1: first fetch, ack two cycles after reset release ----
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1_req",   {31'd0, inst_req}, 32'd1);
    check("t1_addr",  inst_addr,         32'h0);
    check("t1_p4",    pc_plus4,          32'h4);
    @(negedge clk);
    check("t1_req_held", {31'd0, inst_req}, 32'd1);
    inst_ack   = 1'b1;
    inst_rdata = 32'h2008_0005;
    @(negedge clk);
    inst_ack = 1'b0;
    check("t1_valid",    {31'd0, inst_valid}, 32'd1);
    check("t1_req_drop", {31'd0, inst_req},   32'd0);
    check("t1_inst",     inst,                32'h2008_0005);
    @(negedge clk);
    exp_count++;
    check("t1_valid_drop", {31'd0, inst_valid}, 32'd0);
    check("t1_pc",         pc,                  32'h4);
    check("t1_count",      inst_count,          exp_count);
    check("t1_addr2",      inst_addr,           32'h4);

    // ---- 2: branch with negative offset, then not taken ----
    run_inst("t2_jr_a", 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
    check("t2_pc_a", pc, 32'h10);
    check("t2_merr_none", {31'd0, misalign_err}, 32'd0);
    run_inst("t2_br", 32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_taken", pc, 32'h4);
    run_inst("t2_jr_b", 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
    run_inst("t2_nt", 32'h1000_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t2_not_taken", pc, 32'h14);

    // ---- 3: jump, and jump beating pc_src ----
    run_inst("t3_jr_a", 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h4000_0010);
    run_inst("t3_j", 32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t3_jump", pc, 32'h4000_0100);
    run_inst("t3_jr_b", 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h4000_0010);
    run_inst("t3_jb", 32'h0800_0040, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_jump_over_br", pc, 32'h4000_0100);

    // ---- 4: jr beats jump, misaligned target ----
    run_inst("t4", 32'h0800_0040, 1'b0, 1'b1, 1'b1, 32'h0000_0203);
    check("t4_pc",   pc,                    32'h200);
    check("t4_merr", {31'd0, misalign_err}, 32'd1);
    @(negedge clk);
    check("t4_merr_pulse", {31'd0, misalign_err}, 32'd0);
    check("t4_count", inst_count, exp_count);

    // ---- 5: three stall cycles with a stray ack ----
    wait_fetch("t5_req");
    inst_ack   = 1'b1;
    inst_rdata = 32'h0123_4567;
    @(negedge clk);
    valid_cycles = 0;
    stall      = 1'b1;
    inst_ack   = 1'b1;               // stray ack while in execute
    inst_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      if (inst_valid === 1'b1) valid_cycles++;
      if (i == 1) inst_ack = 1'b0;
      if (i == 3) stall = 1'b0;      // three stalled edges, then exit
      @(negedge clk);
      if (i < 3) begin
        check("t5_inst_hold", inst, 32'h0123_4567);
        check("t5_pc_hold",   pc,   32'h200);
      end
    end
    exp_count++;
    check("t5_valid_cycles", valid_cycles, 32'd4);
    check("t5_valid_drop",   {31'd0, inst_valid}, 32'd0);
    check("t5_pc",           pc,         32'h204);
    check("t5_count",        inst_count, exp_count);

    // ---- 6a: reset in the middle of a fetch ----
    wait_fetch("t6_req");
    rst = 1'b1;
    #1;
    check("t6_req_drop", {31'd0, inst_req}, 32'd0);
    check("t6_pc_reset", pc,                32'h0);
    check("t6_count_rst", inst_count,       32'd0);
    exp_count = 0;
    inst_ack   = 1'b1;               // late ack must be ignored
    inst_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rst      = 1'b0;
    inst_ack = 1'b0;
    @(negedge clk);
    check("t6_after_req",   {31'd0, inst_req},   32'd1);
    check("t6_after_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_after_inst",  inst,                32'h0);

    // ---- 6b: sequential wrap at the top of the address space ----
    run_inst("t6_jr", 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("t6_pc_top", pc,       32'hFFFF_FFFC);
    check("t6_p4_wrap", pc_plus4, 32'h0);
    run_inst("t6_seq", 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t6_pc_wrap", pc,         32'h0);
    check("t6_count",   inst_count, exp_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_inst_fetch_unit
